bus_rr_scheduler: RTL and testbench

Round-robin scheduler and router for the shared packet bus. It arbitrates among `DRVS` source FIFOs that signal `pndng`, pops one packet from the granted source, and decodes the destination ID in the packet header. It then pushes the packet onto the shared output bus into the destination FIFO(s), holding off while any targeted FIFO is full. It sits between the per-driver FIFOs and the bus interface, in place of the bus generator/arbiter's control path.

---
 rtl/bus_rr_scheduler_pkg.sv | 40 ++++
 rtl/bus_rr_scheduler_rr_picker.sv | 33 +++
 rtl/bus_rr_scheduler.sv | 125 ++++++++++++
 tb/tb_bus_rr_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_rr_scheduler_pkg.sv
// Shared types and helpers for bus_rr_scheduler: FSM state encoding,
// header field constants and destination-mask decoding.
package bus_rr_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_DELIVER = 2'd2
  } sched_state_e;

  localparam int             ID_W      = 8;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
  localparam int             MAX_DRVS  = 16;
  localparam int             MAX_IDX_W = 4;

  typedef struct packed {
    logic                valid;
    logic [MAX_DRVS-1:0] mask;
  } dest_res_t;

  // Broadcast targets everyone but the source; unicast must name another
  // existing driver. Anything else comes back with valid=0 and an empty mask.
  function automatic dest_res_t dest_mask(input logic [ID_W-1:0]      dest,
                                          input logic [MAX_IDX_W-1:0] src,
                                          input int                   drvs);
    dest_res_t res;
    res = '0;
    if (dest == BCAST_ID) begin
      res.valid = 1'b1;
      for (int i = 0; i < MAX_DRVS; i++) begin
        if (i < drvs && i != int'(src)) res.mask[i] = 1'b1;
      end
    end else if (int'(dest) < drvs && int'(dest) != int'(src)) begin
      res.valid = 1'b1;
      res.mask[dest[MAX_IDX_W-1:0]] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_rr_scheduler_rr_picker.sv
// Combinational round-robin picker: the search starts just after `last`
// and wraps, so the most recently served requester has lowest priority.
module rr_picker #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last) + k) % N;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
    if (w_found) gnt[gnt_idx] = 1'b1;
  end

  assign any = |req;

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler/router for the shared packet bus.
// Optional per-source and drop statistics under BUS_RR_SCHED_STATS_EN.
module bus_rr_scheduler
  import bus_rr_sched_pkg::*;
#(
  parameter int DRVS    = 8,
  parameter int PCKG_SZ = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DRVS-1:0]                 pndng,
  input  logic [DRVS-1:0][PCKG_SZ-1:0]    D_pop,
  output logic [DRVS-1:0]                 pop,
  input  logic [DRVS-1:0]                 full,
  output logic [DRVS-1:0]                 push,
  output logic [PCKG_SZ-1:0]              D_push,
  output logic                            busy,
  output logic [1:0]                      o_state
`ifdef BUS_RR_SCHED_STATS_EN
  ,
  output logic [DRVS-1:0][15:0]           grant_cnt,
  output logic [15:0]                     drop_cnt
`endif
);

  localparam int IDX_W = $clog2(DRVS);

  // Handshake: a source offers a word while pndng is high and sees it
  // consumed on the cycle pop is high; a destination takes D_push on any
  // cycle its push bit is high, and push is never raised while its full is.

  sched_state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_src;
  logic [IDX_W-1:0]       r_last;
  logic [PCKG_SZ-1:0]     r_pkt;
  logic [DRVS-1:0]        r_pop;

  logic [IDX_W-1:0]       w_pick_last;
  logic [DRVS-1:0]        w_gnt;
  logic [IDX_W-1:0]       w_gnt_idx;
  logic                   w_any;
  logic                   w_load_grant;
  logic                   w_done;
  logic                   w_blocked;
  dest_res_t              w_dm;
  logic [DRVS-1:0]        w_mask;
  logic                   w_unused_mask;

  // On completion the just-served source becomes `last` in the same cycle.
  assign w_pick_last = (r_state == S_DELIVER) ? r_src : r_last;

  rr_picker #(.N(DRVS), .IDX_W(IDX_W)) u_picker (
    .req     (pndng),
    .last    (w_pick_last),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign w_dm          = dest_mask(r_pkt[PCKG_SZ-1 -: ID_W], MAX_IDX_W'(r_src), DRVS);
  assign w_mask        = w_dm.mask[DRVS-1:0];
  assign w_unused_mask = ^w_dm.mask;
  assign w_blocked     = |(w_mask & full);
  assign w_done        = (r_state == S_DELIVER) && (!w_dm.valid || !w_blocked);

  always_comb begin
    w_state_nxt  = r_state;
    w_load_grant = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt  = S_GRANT;
          w_load_grant = 1'b1;
        end
      end
      S_GRANT: w_state_nxt = S_DELIVER;
      S_DELIVER: begin
        if (w_done) begin
          if (w_any) begin
            w_state_nxt  = S_GRANT;
            w_load_grant = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_last  <= IDX_W'(DRVS - 1);
      r_pkt   <= '0;
      r_pop   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pop   <= w_load_grant ? w_gnt : '0;
      if (w_load_grant) r_src <= w_gnt_idx;
      if (r_state == S_GRANT) r_pkt <= D_pop[r_src];
      if (w_done) r_last <= r_src;
    end
  end

  assign pop     = r_pop;
  assign push    = (r_state == S_DELIVER && w_dm.valid && !w_blocked) ? w_mask : '0;
  assign D_push  = r_pkt;
  assign busy    = (r_state != S_IDLE);
  assign o_state = r_state;

`ifdef BUS_RR_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt <= '0;
      drop_cnt  <= '0;
    end else if (w_done) begin
      if (grant_cnt[r_src] != 16'hFFFF) grant_cnt[r_src] <= grant_cnt[r_src] + 16'd1;
      if (!w_dm.valid && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Self-checking bench for bus_rr_scheduler (DRVS=4, PCKG_SZ=16) with a
// source-FIFO model, expected push/pop queues and directed plus random cases.
module tb_bus_rr_scheduler;

  localparam int DRVS    = 4;
  localparam int PCKG_SZ = 16;

  logic                         clk;
  logic                         rst_n;
  logic [DRVS-1:0]              pndng;
  logic [DRVS-1:0][PCKG_SZ-1:0] D_pop;
  logic [DRVS-1:0]              pop;
  logic [DRVS-1:0]              full;
  logic [DRVS-1:0]              push;
  logic [PCKG_SZ-1:0]           D_push;
  logic                         busy;
  logic [1:0]                   o_state;
`ifdef BUS_RR_SCHED_STATS_EN
  logic [DRVS-1:0][15:0]        grant_cnt;
  logic [15:0]                  drop_cnt;
`endif

  bus_rr_scheduler #(.DRVS(DRVS), .PCKG_SZ(PCKG_SZ)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .pndng   (pndng),
    .D_pop   (D_pop),
    .pop     (pop),
    .full    (full),
    .push    (push),
    .D_push  (D_push),
    .busy    (busy),
    .o_state (o_state)
`ifdef BUS_RR_SCHED_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // scoreboard state
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [19:0] exp_q[$];
  int          exp_pop_q[$];
  int          pop_cyc_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // source FIFO model
  logic [PCKG_SZ-1:0] src_mem[DRVS][16];
  int                 src_wr[DRVS];
  int                 src_rd[DRVS];

  task automatic refresh();
    for (int i = 0; i < DRVS; i++) begin
      pndng[i] = (src_wr[i] != src_rd[i]);
      D_pop[i] = pndng[i] ? src_mem[i][src_rd[i] % 16] : '0;
    end
  endtask

  function automatic logic [3:0] ref_mask(input int s, input logic [7:0] d);
    logic [3:0] m;
    m = 4'h0;
    if (d == 8'hFF) begin
      m = 4'hF;
      m[s] = 1'b0;
    end else if (d < 8'd4 && int'(d) != s) begin
      m[d[1:0]] = 1'b1;
    end
    return m;
  endfunction

  // driver tasks
  task automatic send(input int s, input logic [PCKG_SZ-1:0] pkt, input logic [3:0] m);
    src_mem[s][src_wr[s] % 16] = pkt;
    src_wr[s]++;
    exp_pop_q.push_back(s);
    if (m != 4'h0) exp_q.push_back({m, pkt});
    refresh();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || (|pndng) || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  // consume the popped word on the same edge the DUT captures it
  always @(negedge clk) begin
    logic [DRVS-1:0] p;
    if (rst_n && (|pop)) begin
      p = pop;
      @(posedge clk);
      #1;
      for (int i = 0; i < DRVS; i++) if (p[i] && src_rd[i] != src_wr[i]) src_rd[i]++;
      refresh();
    end
  end

  // output monitor
  always @(negedge clk) begin
    logic [19:0] e;
    int          s;
    if (rst_n) begin
      if (|push) begin
        check("push_vs_full", {28'h0, push & full}, 32'h0);
        if (exp_q.size() == 0) begin
          check("unexp_push", {12'h0, push, D_push}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("push", {12'h0, push, D_push}, {12'h0, e});
        end
      end
      if (|pop) begin
        pop_cyc_q.push_back(cyc);
        if (exp_pop_q.size() == 0) begin
          check("unexp_pop", {28'h0, pop}, 32'h0);
        end else begin
          s = exp_pop_q.pop_front();
          check("pop", {28'h0, pop}, 32'h1 << s);
        end
      end
    end
  end

  initial begin
    logic [7:0]  d;
    logic [15:0] pkt;
    int          s;
    int          r;

    rst_n = 1'b0;
    full  = '0;
    for (int i = 0; i < DRVS; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    refresh();

    // reset state
    repeat (3) @(negedge clk);
    check("rst_pop", {28'h0, pop}, 32'h0);
    check("rst_push", {28'h0, push}, 32'h0);
    check("rst_dpush", {16'h0, D_push}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_state", {30'h0, o_state}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // single unicast with latency
    send(1, 16'h02AB, 4'b0100);
    @(negedge clk);
    check("uni_pop_n1", {28'h0, pop}, 32'h2);
    check("uni_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("uni_push_n2", {28'h0, push}, 32'h4);
    check("uni_dpush_n2", {16'h0, D_push}, 32'h02AB);
    check("uni_nopop_n2", {28'h0, pop}, 32'h0);
    wait_idle();

    // broadcast
    send(0, 16'hFF55, 4'b1110);
    wait_idle();

    // backpressure
    full = 4'b1000;
    send(2, 16'h0377, 4'b1000);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", {28'h0, push}, 32'h0);
    end
    @(posedge clk);
    #1 full = 4'b0000;
    #1;
    check("bp_release_push", {28'h0, push}, 32'h8);
    check("bp_release_data", {16'h0, D_push}, 32'h0377);
    wait_idle();

    // invalid dest and self-addressed
    send(1, 16'h0712, 4'b0000);
    send(1, 16'h0134, 4'b0000);
    wait_idle();
    check("inval_pops_done", 32'(exp_pop_q.size()), 32'd0);
`ifdef BUS_RR_SCHED_STATS_EN
    check("drop_cnt", {16'h0, drop_cnt}, 32'd2);
    check("grant_cnt0", {16'h0, grant_cnt[0]}, 32'd1);
    check("grant_cnt1", {16'h0, grant_cnt[1]}, 32'd3);
    check("grant_cnt2", {16'h0, grant_cnt[2]}, 32'd1);
    check("grant_cnt3", {16'h0, grant_cnt[3]}, 32'd0);
`endif

    // reset during a blocked DELIVER; the packet is lost
    full = 4'hF;
    send(3, 16'h0099, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", {31'h0, busy}, 32'h1);
    check("mid_blocked", {28'h0, push}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_pop", {28'h0, pop}, 32'h0);
    check("arst_push", {28'h0, push}, 32'h0);
    check("arst_dpush", {16'h0, D_push}, 32'h0);
    check("arst_state", {30'h0, o_state}, 32'h0);
    full = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // fairness: every source pending, driver 0 first after reset
    pop_cyc_q.delete();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DRVS; i++) begin
        d = 8'((i + 1) % DRVS);
        send(i, {d, 8'(i * 16 + k)}, ref_mask(i, d));
      end
    end
    wait_idle();
    check("fair_pop_count", 32'(pop_cyc_q.size()), 32'd8);
    for (int i = 1; i < pop_cyc_q.size(); i++)
      check("fair_pop_gap", 32'(pop_cyc_q[i] - pop_cyc_q[i-1]), 32'd2);

    // random single packets with random backpressure
    for (int n = 0; n < 16; n++) begin
      s   = $urandom_range(0, DRVS - 1);
      r   = $urandom_range(0, 5);
      d   = (r == 5) ? 8'hFF : 8'(r);
      pkt = {d, 8'($urandom_range(0, 255))};
      full = 4'($urandom_range(0, 15));
      send(s, pkt, ref_mask(s, d));
      repeat ($urandom_range(2, 6)) @(negedge clk);
      full = 4'h0;
      wait_idle();
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp_pop_q_empty", 32'(exp_pop_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
